// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice: operation encodings and default datapath width.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   typedef enum logic [2:0] {
      MODE_ADD = 3'b000,
      MODE_SUB = 3'b001,
      MODE_AND = 3'b010,
      MODE_OR  = 3'b011,
      MODE_XOR = 3'b100,
      MODE_NOT = 3'b101,
      MODE_SHL = 3'b110,
      MODE_SHR = 3'b111
   } mode_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result, carry/borrow/shift-out and signed overflow.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       mode,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   always_comb begin
      // One extra bit: sum[WIDTH] is the carry, diff[WIDTH] is the borrow.
      sum    = {1'b0, A} + {1'b0, B};
      diff   = {1'b0, A} - {1'b0, B};
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (mode_e'(mode))
         MODE_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         MODE_SUB: begin
            result = diff[WIDTH-1:0];
            carry  = diff[WIDTH];
            ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         MODE_AND: result = A & B;
         MODE_OR:  result = A | B;
         MODE_XOR: result = A ^ B;
         MODE_NOT: result = ~A;
         MODE_SHL: begin
            result = {A[WIDTH-2:0], 1'b0};
            carry  = A[WIDTH-1];
         end
         MODE_SHR: begin
            result = {1'b0, A[WIDTH-1:1]};
            carry  = A[0];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
            ovf    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu.sv
// Registered ALU slice: one-cycle latency result and flags, zero detect on the next result.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       mode,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             zero,
   output logic             ovf
);

   logic [WIDTH-1:0] result_nxt;
   logic             carry_nxt;
   logic             ovf_nxt;
   logic             zero_nxt;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .A      (A),
      .B      (B),
      .mode   (mode),
      .result (result_nxt),
      .carry  (carry_nxt),
      .ovf    (ovf_nxt)
   );

   // Zero comes from the next result so it lands in the same cycle as out.
   assign zero_nxt = (result_nxt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out   <= '0;
         carry <= 1'b0;
         zero  <= 1'b1;
         ovf   <= 1'b0;
      end else begin
         out   <= result_nxt;
         carry <= carry_nxt;
         zero  <= zero_nxt;
         ovf   <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed rows, corner cases and randomized back-to-back traffic.
module tb_alu;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [2:0]   mode;
   logic [W-1:0] out;
   logic         carry;
   logic         zero;
   logic         ovf;

   int n_cmp;
   int n_err;

   alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .mode  (mode),
      .out   (out),
      .carry (carry),
      .zero  (zero),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: integer arithmetic; overflow = signed result outside the 8-bit signed range.
   function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] m);
      int ua, ub, sa, sb, r;
      logic [7:0] o;
      logic c, v;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      c = 1'b0; v = 1'b0; o = 8'h00;
      case (m)
         3'd0: begin r = ua + ub; o = 8'(r); c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
         3'd1: begin r = ua - ub; o = 8'(r); c = (ua < ub);  v = (sa - sb > 127) || (sa - sb < -128); end
         3'd2: o = a & b;
         3'd3: o = a | b;
         3'd4: o = a ^ b;
         3'd5: o = 8'(255 - ua);
         3'd6: begin o = 8'(ua * 2); c = (ua >= 128); end
         default: begin o = 8'(ua / 2); c = (ua % 2 == 1); end
      endcase
      return {o, c, (o == 8'h00), v};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; A = 8'h00; B = 8'h00; mode = 3'd0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({out, carry, zero, ovf} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL reset_hold: out=%h c=%b z=%b v=%b, want out=00 c=0 z=1 v=0", out, carry, zero, ovf);
      end
      rst_n = 1'b1;
      A = 8'hFF; B = 8'h01; mode = 3'd0;
      @(negedge clk);
      n_cmp++;
      if ({out, carry, zero, ovf} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL reset_release: out=%h c=%b z=%b v=%b, want out=00 c=1 z=1 v=0", out, carry, zero, ovf);
      end
      A = 8'h7F; B = 8'h01; mode = 3'd0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out, carry, zero, ovf} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL reset_async: out=%h c=%b z=%b v=%b, want out=00 c=0 z=1 v=0", out, carry, zero, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mode_sweep();
      logic [10:0] exp_tab [8];
      exp_tab[0] = {8'h03, 1'b0, 1'b0, 1'b0};
      exp_tab[1] = {8'h01, 1'b0, 1'b0, 1'b0};
      exp_tab[2] = {8'h00, 1'b0, 1'b1, 1'b0};
      exp_tab[3] = {8'h03, 1'b0, 1'b0, 1'b0};
      exp_tab[4] = {8'h03, 1'b0, 1'b0, 1'b0};
      exp_tab[5] = {8'hFD, 1'b0, 1'b0, 1'b0};
      exp_tab[6] = {8'h04, 1'b0, 1'b0, 1'b0};
      exp_tab[7] = {8'h01, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         A = 8'h02; B = 8'h01; mode = 3'(i);
         @(negedge clk);
         n_cmp++;
         if ({out, carry, zero, ovf} !== exp_tab[i]) begin
            n_err++;
            $display("FAIL sweep_mode%0d: got out=%h c=%b z=%b v=%b, want %h/%b/%b/%b", i,
                     out, carry, zero, ovf, exp_tab[i][10:3], exp_tab[i][2], exp_tab[i][1], exp_tab[i][0]);
         end
      end
   endtask

   task automatic test_corners();
      logic [7:0]  ca [6];
      logic [7:0]  cb [6];
      logic [2:0]  cm [6];
      logic [10:0] ce [6];
      ca[0] = 8'hFF; cb[0] = 8'h01; cm[0] = 3'd0; ce[0] = {8'h00, 1'b1, 1'b1, 1'b0};
      ca[1] = 8'h7F; cb[1] = 8'h01; cm[1] = 3'd0; ce[1] = {8'h80, 1'b0, 1'b0, 1'b1};
      ca[2] = 8'h01; cb[2] = 8'h02; cm[2] = 3'd1; ce[2] = {8'hFF, 1'b1, 1'b0, 1'b0};
      ca[3] = 8'h80; cb[3] = 8'h01; cm[3] = 3'd1; ce[3] = {8'h7F, 1'b0, 1'b0, 1'b1};
      ca[4] = 8'h81; cb[4] = 8'h55; cm[4] = 3'd6; ce[4] = {8'h02, 1'b1, 1'b0, 1'b0};
      ca[5] = 8'h81; cb[5] = 8'h55; cm[5] = 3'd7; ce[5] = {8'h40, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         A = ca[i]; B = cb[i]; mode = cm[i];
         @(negedge clk);
         n_cmp++;
         if ({out, carry, zero, ovf} !== ce[i]) begin
            n_err++;
            $display("FAIL corner%0d: A=%h B=%h mode=%0d got out=%h c=%b z=%b v=%b, want %h/%b/%b/%b",
                     i, ca[i], cb[i], cm[i], out, carry, zero, ovf,
                     ce[i][10:3], ce[i][2], ce[i][1], ce[i][0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp_q [$];
      logic [10:0] e;
      for (int i = 0; i < 200; i++) begin
         A = 8'($urandom); B = 8'($urandom); mode = 3'(i % 8 + (i / 8) % 3) ;
         if (i % 5 == 0) B = A;
         exp_q.push_back(model(A, B, mode));
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({out, carry, zero, ovf} !== e) begin
            n_err++;
            $display("FAIL b2b%0d: got out=%h c=%b z=%b v=%b, want %h/%b/%b/%b",
                     i, out, carry, zero, ovf, e[10:3], e[2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_random();
      logic [10:0] e;
      for (int i = 0; i < 300; i++) begin
         A = 8'($urandom); B = 8'($urandom); mode = 3'($urandom_range(7, 0));
         e = model(A, B, mode);
         @(negedge clk);
         n_cmp++;
         if ({out, carry, zero, ovf} !== e) begin
            n_err++;
            $display("FAIL rand%0d: got out=%h c=%b z=%b v=%b, want %h/%b/%b/%b",
                     i, out, carry, zero, ovf, e[10:3], e[2], e[1], e[0]);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_mode_sweep();
      test_corners();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
